// File: rtl/dma_copy_host.sv
// dma_copy_host
//    Word-granular memory-to-memory copy engine. It is programmed through a
//    device-side register port and moves data as a bus host, one transaction
//    outstanding at a time. irq_o is a level interrupt on completion or bus
//    error, held until software writes CTRL bit1.
//
//    Optional build macro: DMA_COPY_FILL_EN. When defined, the engine can write
//    the FILL register value to LEN words at DST without reading the source.
//
// Ports
//    clk_i, rst_i               clock, synchronous active-high reset
//    device_req_i .. _wdata_i   register access (bits [4:2] of the address decoded)
//    device_rvalid_o/_rdata_o   register response, exactly one cycle after req
//    host_req_o .. _wdata_o     bus host request (held until host_gnt_i)
//    host_gnt_i                 bus grant
//    host_rvalid_i/_rdata_i     bus response
//    host_err_i                 bus error, qualified by host_rvalid_i
//    irq_o                      done | err
//
// Register map (word offset)
//    0x00 SRC   0x04 DST   0x08 LEN   0x0C CTRL/STATUS   0x10 FILL
//    CTRL write: bit0 start, bit1 clear done/err, bit3 fill
//    STATUS read: bit0 busy, bit1 done, bit2 err, bit3 fill

module dma_copy_host #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32,
   parameter int LenWidth  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 device_req_i,
   input  logic [AddrWidth-1:0] device_addr_i,
   input  logic                 device_we_i,
   input  logic [3:0]           device_be_i,
   input  logic [DataWidth-1:0] device_wdata_i,
   output logic                 device_rvalid_o,
   output logic [DataWidth-1:0] device_rdata_o,
   output logic                 host_req_o,
   input  logic                 host_gnt_i,
   output logic [AddrWidth-1:0] host_addr_o,
   output logic                 host_we_o,
   output logic [3:0]           host_be_o,
   output logic [DataWidth-1:0] host_wdata_o,
   input  logic                 host_rvalid_i,
   input  logic [DataWidth-1:0] host_rdata_i,
   input  logic                 host_err_i,
   output logic                 irq_o
);

   // state    | meaning
   // ---------+---------------------------------------------------------
   // IDLE     | waiting for a start write
   // RD_REQ   | read request on the bus, held until grant
   // RD_WAIT  | waiting for the read response
   // WR_REQ   | write request on the bus, held until grant
   // WR_WAIT  | waiting for the write response
   // FINISH   | one cycle to post done, then back to IDLE
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_WR_REQ,
      ST_WR_WAIT,
      ST_FINISH
   } state_e;

   state_e               state_q;
   logic [AddrWidth-1:0] src_q;
   logic [AddrWidth-1:0] dst_q;
   logic [LenWidth-1:0]  len_q;
   logic [AddrWidth-1:0] raddr_q;
   logic [AddrWidth-1:0] waddr_q;
   logic [LenWidth-1:0]  remaining_q;
   logic                 done_q;
   logic                 err_q;
   logic                 host_req_q;
   logic                 host_we_q;
   logic [AddrWidth-1:0] host_addr_q;
   logic [DataWidth-1:0] host_wdata_q;
   logic                 dev_rvalid_q;
   logic [DataWidth-1:0] dev_rdata_q;
   logic [DataWidth-1:0] rd_mux;

   logic                 busy;
   logic [2:0]           reg_sel;
   logic                 reg_wr;
   logic                 cfg_wr;
   logic                 ctrl_wr;
   logic                 start_go;
   logic                 clear_go;
   logic                 fill_start;
   logic                 fill_active;
   logic [DataWidth-1:0] fill_word;

   logic                 unused_addr_bits;

   assign busy     = (state_q != ST_IDLE);
   assign reg_sel  = device_addr_i[4:2];
   assign reg_wr   = device_req_i & device_we_i & (device_be_i == 4'hF);
   assign cfg_wr   = reg_wr & ~busy;
   assign ctrl_wr  = reg_wr & (reg_sel == 3'd3);
   assign start_go = ctrl_wr & device_wdata_i[0] & ~busy;
   assign clear_go = ctrl_wr & device_wdata_i[1];

   assign unused_addr_bits = ^{device_addr_i[AddrWidth-1:5], device_addr_i[1:0]};

`ifdef DMA_COPY_FILL_EN
   logic [DataWidth-1:0] fill_q;
   logic                 fill_mode_q;

   assign fill_start  = device_wdata_i[3];
   assign fill_active = fill_mode_q;
   assign fill_word   = fill_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fill_q      <= '0;
         fill_mode_q <= 1'b0;
      end else begin
         if (cfg_wr && reg_sel == 3'd4) fill_q <= device_wdata_i;
         if (start_go)                  fill_mode_q <= device_wdata_i[3];
      end
   end
`else
   assign fill_start  = 1'b0;
   assign fill_active = 1'b0;
   assign fill_word   = '0;
`endif

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         3'd0:    rd_mux = DataWidth'(src_q);
         3'd1:    rd_mux = DataWidth'(dst_q);
         3'd2:    rd_mux = DataWidth'(len_q);
         3'd3:    rd_mux = DataWidth'({fill_active, err_q, done_q, busy});
`ifdef DMA_COPY_FILL_EN
         3'd4:    rd_mux = fill_q;
`endif
         default: rd_mux = '0;
      endcase
   end

   // Configuration registers and the device response path.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
         dev_rvalid_q <= 1'b0;
         dev_rdata_q  <= '0;
      end else begin
         dev_rvalid_q <= device_req_i;
         dev_rdata_q  <= (device_req_i && !device_we_i) ? rd_mux : '0;
         if (cfg_wr) begin
            case (reg_sel)
               3'd0:    src_q <= {device_wdata_i[AddrWidth-1:2], 2'b00};
               3'd1:    dst_q <= {device_wdata_i[AddrWidth-1:2], 2'b00};
               3'd2:    len_q <= device_wdata_i[LenWidth-1:0];
               default: ;
            endcase
         end
      end
   end

   // Transfer sequencer. Bus outputs are registered and change only on state
   // transitions, so they stay stable for as long as a grant is withheld.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         raddr_q      <= '0;
         waddr_q      <= '0;
         remaining_q  <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         host_req_q   <= 1'b0;
         host_we_q    <= 1'b0;
         host_addr_q  <= '0;
         host_wdata_q <= '0;
      end else begin
         // Clear goes first so a set from the sequencer in the same cycle wins.
         if (clear_go) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               if (start_go) begin
                  done_q      <= 1'b0;
                  err_q       <= 1'b0;
                  raddr_q     <= src_q;
                  waddr_q     <= dst_q;
                  remaining_q <= len_q;
                  if (len_q == '0) begin
                     state_q <= ST_FINISH;
                  end else if (fill_start) begin
                     state_q      <= ST_WR_REQ;
                     host_req_q   <= 1'b1;
                     host_we_q    <= 1'b1;
                     host_addr_q  <= dst_q;
                     host_wdata_q <= fill_word;
                  end else begin
                     state_q     <= ST_RD_REQ;
                     host_req_q  <= 1'b1;
                     host_we_q   <= 1'b0;
                     host_addr_q <= src_q;
                  end
               end
            end
            ST_RD_REQ: begin
               if (host_gnt_i) begin
                  state_q     <= ST_RD_WAIT;
                  host_req_q  <= 1'b0;
                  host_addr_q <= '0;
                  raddr_q     <= raddr_q + AddrWidth'(4);
               end
            end
            ST_RD_WAIT: begin
               if (host_rvalid_i) begin
                  if (host_err_i) begin
                     err_q   <= 1'b1;
                     state_q <= ST_FINISH;
                  end else begin
                     // The write-data register doubles as the word buffer.
                     state_q      <= ST_WR_REQ;
                     host_req_q   <= 1'b1;
                     host_we_q    <= 1'b1;
                     host_addr_q  <= waddr_q;
                     host_wdata_q <= host_rdata_i;
                  end
               end
            end
            ST_WR_REQ: begin
               if (host_gnt_i) begin
                  state_q      <= ST_WR_WAIT;
                  host_req_q   <= 1'b0;
                  host_we_q    <= 1'b0;
                  host_addr_q  <= '0;
                  host_wdata_q <= '0;
                  waddr_q      <= waddr_q + AddrWidth'(4);
               end
            end
            ST_WR_WAIT: begin
               if (host_rvalid_i) begin
                  if (host_err_i) begin
                     err_q   <= 1'b1;
                     state_q <= ST_FINISH;
                  end else begin
                     remaining_q <= remaining_q - LenWidth'(1);
                     if (remaining_q == LenWidth'(1)) begin
                        state_q <= ST_FINISH;
                     end else if (fill_active) begin
                        state_q      <= ST_WR_REQ;
                        host_req_q   <= 1'b1;
                        host_we_q    <= 1'b1;
                        host_addr_q  <= waddr_q;
                        host_wdata_q <= fill_word;
                     end else begin
                        state_q     <= ST_RD_REQ;
                        host_req_q  <= 1'b1;
                        host_we_q   <= 1'b0;
                        host_addr_q <= raddr_q;
                     end
                  end
               end
            end
            ST_FINISH: begin
               // An aborted transfer reports err only, not done.
               if (!err_q) done_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign device_rvalid_o = dev_rvalid_q;
   assign device_rdata_o  = dev_rdata_q;
   assign host_req_o      = host_req_q;
   assign host_we_o       = host_we_q;
   assign host_addr_o     = host_addr_q;
   assign host_wdata_o    = host_wdata_q;
   assign host_be_o       = host_req_q ? 4'hF : 4'h0;
   assign irq_o           = done_q | err_q;

endmodule
